// File: rtl/corr_streamer.sv
// Streaming cross-correlator: loads WIN reference and LAGS+WIN-1 signal samples, then emits one
// unsigned 21-bit sum per lag. Optional abort input enabled by macro CORR_STREAMER_ABORT_EN.
module corr_streamer #(
   parameter int WIN  = 32,
   parameter int LAGS = 4980
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ref_we,
   input  logic [7:0]  ref_in,
   input  logic        sig_we,
   input  logic [7:0]  sig_in,
   input  logic        start,
`ifdef CORR_STREAMER_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic [20:0] data,
   output logic        ena,
   output logic        done
);

   // state | meaning
   // IDLE  | loading samples, waiting for start with both buffers full
   // MAC   | cnt 0..WIN-1 multiply; cnt==WIN flushes the product register
   // EMIT  | publish accumulator on data with ena, advance lag
   // FIN   | last lag emitted; pulse done, clear pointers
   typedef enum logic [1:0] {IDLE, MAC, EMIT, FIN} state_t;

   localparam int SDEPTH = LAGS + WIN - 1;
   localparam int RAW    = $clog2(WIN);
   localparam int RPW    = $clog2(WIN + 1);
   localparam int SAW    = $clog2(SDEPTH);
   localparam int SPW    = $clog2(SDEPTH + 1);

   state_t           state, state_d;
   logic [7:0]       ref_mem [WIN];
   logic [7:0]       sig_mem [SDEPTH];
   logic [RPW-1:0]   ref_ptr, cnt;
   logic [SPW-1:0]   sig_ptr, sidx_full;
   logic [SAW-1:0]   lag, sidx;
   logic [RAW-1:0]   ridx;
   logic [15:0]      prod;
   logic [20:0]      acc;
   logic             ref_full, sig_full, ref_wr, sig_wr;
   logic             mac_active, last_lag, accept, abort_hit;

   assign ref_full   = (ref_ptr == RPW'(WIN));
   assign sig_full   = (sig_ptr == SPW'(SDEPTH));
   assign busy       = (state != IDLE) | done;
   assign ref_wr     = ref_we & ~busy & ~ref_full;
   assign sig_wr     = sig_we & ~busy & ~sig_full;
   assign mac_active = (cnt < RPW'(WIN));
   assign last_lag   = (lag == SAW'(LAGS - 1));
   assign ridx       = mac_active ? cnt[RAW-1:0] : '0;
   assign sidx_full  = SPW'(lag) + SPW'(cnt);
   assign sidx       = mac_active ? sidx_full[SAW-1:0] : lag;

`ifdef CORR_STREAMER_ABORT_EN
   assign abort_hit = abort & (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // Sample memories carry no reset; they are reloaded before every run.
   always_ff @(posedge clk) begin
      if (ref_wr) ref_mem[ref_ptr[RAW-1:0]] <= ref_in;
      if (sig_wr) sig_mem[sig_ptr[SAW-1:0]] <= sig_in;
   end

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      case (state)
         IDLE: if (start && !done && ref_full && sig_full) begin
            accept  = 1'b1;
            state_d = MAC;
         end
         MAC:  if (!mac_active) state_d = EMIT;
         EMIT: state_d = last_lag ? FIN : MAC;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_hit) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ena     <= 1'b0;
         done    <= 1'b0;
         data    <= '0;
         acc     <= '0;
         prod    <= '0;
         cnt     <= '0;
         lag     <= '0;
         ref_ptr <= '0;
         sig_ptr <= '0;
      end else begin
         state <= state_d;
         ena   <= 1'b0;
         done  <= 1'b0;
         if (ref_wr) ref_ptr <= ref_ptr + RPW'(1);
         if (sig_wr) sig_ptr <= sig_ptr + SPW'(1);
         if (abort_hit) begin
            ref_ptr <= '0;
            sig_ptr <= '0;
         end else begin
            case (state)
               IDLE: if (accept) begin
                  cnt  <= '0;
                  lag  <= '0;
                  acc  <= '0;
                  prod <= '0;
               end
               MAC: begin
                  // One-stage product pipeline: acc trails prod by one cycle.
                  prod <= mac_active ? ({8'd0, ref_mem[ridx]} * {8'd0, sig_mem[sidx]}) : '0;
                  acc  <= acc + {5'd0, prod};
                  cnt  <= cnt + RPW'(1);
               end
               EMIT: begin
                  data <= acc;
                  ena  <= 1'b1;
                  acc  <= '0;
                  prod <= '0;
                  cnt  <= '0;
                  lag  <= lag + SAW'(1);
               end
               FIN: begin
                  done    <= 1'b1;
                  ref_ptr <= '0;
                  sig_ptr <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
